// File: rtl/aes_iter_cipher_ctrl_pkg.sv
// Shared types, S-box and GF(2^8) helper for the iterative AES-128 cipher controller.
package aes_iter_cipher_ctrl_pkg;

    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [7:0] RCON_START = 8'h01;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_iter_cipher_ctrl_if.sv
// Block-in / ciphertext-out handshake bundle plus status of the AES controller.
interface aes_iter_cipher_ctrl_if;
    import aes_iter_cipher_ctrl_pkg::*;

    logic       in_valid;
    logic       in_ready;
    block_t     in_data;
    block_t     in_key;
    logic       out_valid;
    logic       out_ready;
    block_t     out_data;
    logic       busy;
    logic [3:0] round;

    modport slave (
        input  in_valid, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data, busy, round
    );

    modport master (
        output in_valid, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data, busy, round
    );
endinterface

// File: rtl/aes_iter_cipher_ctrl_round_step.sv
// One combinational AES-128 round plus the matching on-the-fly key expansion step.
module aes_round_step
    import aes_iter_cipher_ctrl_pkg::*;
(
    input  block_t     i_state,
    input  block_t     i_rk,
    input  logic [7:0] i_rcon,
    input  logic       i_last,
    output block_t     o_state,
    output block_t     o_rk
);
    logic [7:0]  w_sr [16];
    logic [7:0]  w_mc [16];
    logic [31:0] w_t;
    logic [31:0] w_k0, w_k1, w_k2, w_k3;

    // SubWord(RotWord(w3)) ^ rcon feeds the word-wise xor chain
    assign w_t  = {SBOX[i_rk[23:16]], SBOX[i_rk[15:8]], SBOX[i_rk[7:0]], SBOX[i_rk[31:24]]}
                ^ {i_rcon, 24'h0};
    assign w_k0 = i_rk[127:96] ^ w_t;
    assign w_k1 = i_rk[95:64]  ^ w_k0;
    assign w_k2 = i_rk[63:32]  ^ w_k1;
    assign w_k3 = i_rk[31:0]   ^ w_k2;
    assign o_rk = {w_k0, w_k1, w_k2, w_k3};

    // Byte i sits at row i%4, column i/4; ShiftRows pulls from column (c+r)%4
    for (genvar i = 0; i < 16; i++) begin : g_sr
        localparam int SRC = (i % 4) + 4 * (((i / 4) + (i % 4)) % 4);
        assign w_sr[i] = SBOX[i_state[127 - 8*SRC -: 8]];
    end

    for (genvar c = 0; c < 4; c++) begin : g_mc
        logic [7:0] w_a0, w_a1, w_a2, w_a3;
        assign w_a0 = w_sr[4*c];
        assign w_a1 = w_sr[4*c+1];
        assign w_a2 = w_sr[4*c+2];
        assign w_a3 = w_sr[4*c+3];
        assign w_mc[4*c]   = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
        assign w_mc[4*c+1] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
        assign w_mc[4*c+2] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
        assign w_mc[4*c+3] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
    end

    for (genvar i = 0; i < 16; i++) begin : g_ark
        assign o_state[127 - 8*i -: 8] = (i_last ? w_sr[i] : w_mc[i]) ^ o_rk[127 - 8*i -: 8];
    end
endmodule

// File: rtl/aes_iter_cipher_ctrl.sv
// Iterative AES-128 encryption controller, one round per clock (IDLE -> ROUND -> DONE).
// Define AES_CTRL_BACK2BACK_EN to accept a new block on the same edge the result drains.
module aes_iter_cipher_ctrl
    import aes_iter_cipher_ctrl_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input logic                   clk,
    input logic                   rst,
    aes_iter_cipher_ctrl_if.slave bus
);
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    state_t     r_fsm, w_fsm_nxt;
    block_t     r_state, r_rk;
    block_t     w_state_nxt, w_rk_nxt;
    logic [3:0] r_round;
    logic [7:0] r_rcon;
    logic       w_last, w_accept;

    assign w_last   = (r_round == LAST_ROUND);
    assign w_accept = bus.in_valid & bus.in_ready;

    aes_round_step u_step (
        .i_state (r_state),
        .i_rk    (r_rk),
        .i_rcon  (r_rcon),
        .i_last  (w_last),
        .o_state (w_state_nxt),
        .o_rk    (w_rk_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_fsm <= S_IDLE;
        else     r_fsm <= w_fsm_nxt;
    end

    // A DONE-state accept can only occur when in_ready includes the drain cycle
    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE:  if (w_accept) w_fsm_nxt = S_ROUND;
            S_ROUND: if (w_last)   w_fsm_nxt = S_DONE;
            S_DONE: begin
                if (w_accept)           w_fsm_nxt = S_ROUND;
                else if (bus.out_ready) w_fsm_nxt = S_IDLE;
            end
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    always_comb begin
`ifdef AES_CTRL_BACK2BACK_EN
        bus.in_ready  = (r_fsm == S_IDLE) | ((r_fsm == S_DONE) & bus.out_ready);
`else
        bus.in_ready  = (r_fsm == S_IDLE);
`endif
        bus.out_valid = (r_fsm == S_DONE);
        bus.out_data  = (r_fsm == S_DONE)  ? r_state : '0;
        bus.busy      = (r_fsm == S_ROUND);
        bus.round     = (r_fsm == S_ROUND) ? r_round : 4'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= '0;
            r_rk    <= '0;
            r_round <= 4'd0;
            r_rcon  <= 8'h00;
        end else if (w_accept) begin
            r_state <= bus.in_data ^ bus.in_key;
            r_rk    <= bus.in_key;
            r_round <= 4'd1;
            r_rcon  <= RCON_START;
        end else if (r_fsm == S_ROUND) begin
            r_state <= w_state_nxt;
            r_rk    <= w_rk_nxt;
            r_round <= r_round + 4'd1;
            r_rcon  <= xtime(r_rcon);
        end
    end
endmodule

// File: doc/aes_iter_cipher_ctrl.md
AES_ITER_CIPHER_CTRL -- requirements
Module: aes_iter_cipher_ctrl

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 10: number of cipher rounds; legal 1..10; only 10 is FIPS-197 compliant, lower values exist for reduced-round debug.
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 in_valid  input  1  plaintext/key offered.
REQ-006 in_ready  output  1  controller accepts a block this cycle.
REQ-007 in_data  input  128  plaintext; [127:120] is FIPS byte 0.
REQ-008 in_key  input  128  AES-128 cipher key; same byte order.
REQ-009 out_valid  output  1  ciphertext available.
REQ-010 out_ready  input  1  consumer takes ciphertext.
REQ-011 out_data  output  128  ciphertext.
REQ-012 busy  output  1  high in ROUND state.
REQ-013 round  output  4  current round counter (0 when not in ROUND).

Function
REQ-014 SHALL implement FSM IDLE, ROUND, DONE; in_ready = (state==IDLE).
REQ-015 IDLE: on in_valid&in_ready, SHALL register state_reg <= in_data^in_key, rk_reg <= in_key, round <= 1, rcon <= 8'h01, go ROUND.
REQ-016 ROUND: each cycle SHALL apply SubBytes, ShiftRows, MixColumns (skipped when round==NUM_ROUNDS), then AddRoundKey with next round key expanded from rk_reg and rcon; register both results.
REQ-017 rcon SHALL advance by GF(2^8) xtime each round (01,02,...,80,1b,36); round SHALL increment by 1.
REQ-018 After the round==NUM_ROUNDS update SHALL go DONE and assert out_valid; out_data = state_reg.
REQ-019 Latency: handshake at edge E0; out_valid high after edge E(NUM_ROUNDS) (10 cycles at default).
REQ-020 DONE: out_valid and out_data SHALL stay stable while out_ready low; on out_ready SHALL go IDLE and drop out_valid next cycle.
REQ-021 in_data/in_key changes outside the accept cycle SHALL have no effect.
REQ-022 out_data SHALL read 0 outside DONE.

Reset
REQ-023 rst SHALL immediately force IDLE, state_reg/rk_reg/out_data=0, round=0, rcon=0, out_valid=0, busy=0; in_ready=1 while rst low again.
REQ-024 rst asserted mid-ROUND or in DONE SHALL discard the block with no output.

Configuration
REQ-025 Macro AES_CTRL_BACK2BACK_EN defined: in_ready = IDLE | (DONE & out_ready); simultaneous drain and accept SHALL go directly DONE->ROUND with the new block loaded per REQ-015.
REQ-026 Macro undefined: in_ready only in IDLE; one idle cycle between blocks.

Structure
REQ-027 Shared package SHALL hold the 128-bit block typedef, FSM state enum, S-box constant table and rcon start constant.
REQ-028 SHALL use one combinational sub-module aes_round_step (inputs state, round key, rcon, last flag; outputs next state, next round key); controller holds registers and FSM only.

Verification
REQ-029 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out_data 3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 cycles after accept.
REQ-030 FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-031 Backpressure: out_ready low 7 cycles in DONE -> out_data stable, in_ready 0, release -> IDLE next cycle.
REQ-032 Reset at round 5 -> all outputs 0 next cycle, no out_valid; new App. B block afterward -> correct result.
REQ-033 Back-to-back with AES_CTRL_BACK2BACK_EN: in_valid held with two vectors -> second accepted on the same edge as the first drain, outputs spaced 11 cycles; without macro, 12 cycles.
REQ-034 Input toggling: in_data randomized every cycle during ROUND -> App. B result unchanged.
